// File: rtl/l2_pkg.sv
// Shared types and widths for the N-way set-associative L2 cache.
package l2_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_WRITEBACK,
        S_ALLOCATE
    } state_t;

    localparam int LINE_W  = 128;
    localparam int ADDR_W  = 30;
    localparam int MADDR_W = 28;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/l2_cache_nway_lru.sv
// True-LRU age tracking per set; ages in a set always form a permutation.
module l2_lru_ages
    import l2_pkg::*;
#(
    parameter int WAYS  = 8,
    parameter int IDX_W = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_touch_en,
    input  logic [IDX_W-1:0]         i_touch_set,
    input  logic [clog2(WAYS)-1:0]   i_touch_way,
    input  logic [IDX_W-1:0]         i_set,
    output logic [clog2(WAYS)-1:0]   o_victim
);
    localparam int WW   = clog2(WAYS);
    localparam int SETS = 2 ** IDX_W;

    logic [WW-1:0] r_age [SETS][WAYS];
    logic [WW-1:0] w_touch_age;

    assign w_touch_age = r_age[i_touch_set][i_touch_way];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_age[s][w] <= WW'(w);
                end
            end
        end else if (i_touch_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (r_age[i_touch_set][w] < w_touch_age) begin
                    r_age[i_touch_set][w] <= r_age[i_touch_set][w] + WW'(1);
                end
            end
            r_age[i_touch_set][i_touch_way] <= '0;
        end
    end

    always_comb begin
        o_victim = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_age[i_set][w] == WW'(WAYS - 1)) o_victim = WW'(w);
        end
    end

endmodule

// File: rtl/l2_cache_nway.sv
// Parametrised N-way write-back L2 cache with true-LRU replacement
// and saturating hit/miss/access counters.
module l2_cache_nway
    import l2_pkg::*;
#(
    parameter int WAYS  = 8,
    parameter int IDX_W = 3,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  i_addr,
    input  logic               i_read,
    input  logic               i_write,
    input  logic [LINE_W-1:0]  i_wdata,
    output logic [LINE_W-1:0]  o_rdata,
    output logic               o_ready,
    output logic               o_stall,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic [MADDR_W-1:0] o_mem_addr,
    output logic [LINE_W-1:0]  o_mem_wdata,
    input  logic [LINE_W-1:0]  i_mem_rdata,
    input  logic               i_mem_ready,
    output logic [CNT_W-1:0]   o_hit_cnt,
    output logic [CNT_W-1:0]   o_miss_cnt,
    output logic [CNT_W-1:0]   o_acc_cnt
);
    localparam int TAG_W = MADDR_W - IDX_W;
    localparam int SETS  = 2 ** IDX_W;
    localparam int WW    = clog2(WAYS);

    logic [WAYS-1:0]   r_valid [SETS];
    logic [WAYS-1:0]   r_dirty [SETS];
    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [LINE_W-1:0] r_data  [SETS][WAYS];

    state_t             r_state, w_state_nxt;
    logic [WW-1:0]      r_victim, w_victim_nxt;
    logic [LINE_W-1:0]  r_rdata, w_rdata_nxt;
    logic               r_ready, w_ready_nxt;
    logic               r_stall, w_stall_nxt;
    logic               r_mem_read, w_mem_read_nxt;
    logic               r_mem_write, w_mem_write_nxt;
    logic [MADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [LINE_W-1:0]  r_mem_wdata, w_mem_wdata_nxt;
    logic [CNT_W-1:0]   r_hit_cnt, r_miss_cnt, r_acc_cnt;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit, w_has_inv, w_vic_dirty;
    logic [WW-1:0]    w_hit_way, w_inv_way, w_lru_way, w_vic_sel;
    logic             w_touch, w_wr_hit, w_fill;
    logic             w_acc_inc, w_hit_inc, w_miss_inc;
    logic             w_unused;

    assign w_idx    = i_addr[IDX_W+1:2];
    assign w_tag    = i_addr[ADDR_W-1:IDX_W+2];
    assign w_unused = ^i_addr[1:0];

    // Scan downwards so the lowest matching way wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_has_inv = 1'b0;
        w_inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_idx][w] && r_tag[w_idx][w] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = WW'(w);
            end
            if (!r_valid[w_idx][w]) begin
                w_has_inv = 1'b1;
                w_inv_way = WW'(w);
            end
        end
    end

    assign w_vic_sel   = w_has_inv ? w_inv_way : w_lru_way;
    assign w_vic_dirty = r_valid[w_idx][w_vic_sel] & r_dirty[w_idx][w_vic_sel];

    l2_lru_ages #(
        .WAYS  (WAYS),
        .IDX_W (IDX_W)
    ) u_lru (
        .clk         (clk),
        .reset       (reset),
        .i_touch_en  (w_touch),
        .i_touch_set (w_idx),
        .i_touch_way (w_hit_way),
        .i_set       (w_idx),
        .o_victim    (w_lru_way)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_victim_nxt    = r_victim;
        w_rdata_nxt     = r_rdata;
        w_ready_nxt     = 1'b0;
        w_stall_nxt     = r_stall;
        w_mem_read_nxt  = r_mem_read;
        w_mem_write_nxt = r_mem_write;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_touch         = 1'b0;
        w_wr_hit        = 1'b0;
        w_fill          = 1'b0;
        w_acc_inc       = 1'b0;
        w_hit_inc       = 1'b0;
        w_miss_inc      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_read || i_write) begin
                    w_state_nxt = S_COMPARE;
                    w_stall_nxt = 1'b1;
                    w_acc_inc   = 1'b1;
                end
            end
            S_COMPARE: begin
                if (w_hit) begin
                    w_state_nxt = S_IDLE;
                    w_ready_nxt = 1'b1;
                    w_stall_nxt = 1'b0;
                    w_touch     = 1'b1;
                    w_hit_inc   = 1'b1;
                    if (i_read) w_rdata_nxt = r_data[w_idx][w_hit_way];
                    else        w_wr_hit    = 1'b1;
                end else begin
                    w_miss_inc   = 1'b1;
                    w_victim_nxt = w_vic_sel;
                    if (w_vic_dirty) begin
                        w_state_nxt     = S_WRITEBACK;
                        w_mem_write_nxt = 1'b1;
                        w_mem_addr_nxt  = {r_tag[w_idx][w_vic_sel], w_idx};
                        w_mem_wdata_nxt = r_data[w_idx][w_vic_sel];
                    end else begin
                        w_state_nxt    = S_ALLOCATE;
                        w_mem_read_nxt = 1'b1;
                        w_mem_addr_nxt = i_addr[ADDR_W-1:2];
                    end
                end
            end
            S_WRITEBACK: begin
                if (i_mem_ready) begin
                    w_state_nxt     = S_ALLOCATE;
                    w_mem_write_nxt = 1'b0;
                    w_mem_read_nxt  = 1'b1;
                    w_mem_addr_nxt  = i_addr[ADDR_W-1:2];
                end
            end
            S_ALLOCATE: begin
                if (i_mem_ready) begin
                    w_state_nxt    = S_COMPARE;
                    w_mem_read_nxt = 1'b0;
                    w_fill         = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_victim    <= '0;
            r_rdata     <= '0;
            r_ready     <= 1'b0;
            r_stall     <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_victim    <= w_victim_nxt;
            r_rdata     <= w_rdata_nxt;
            r_ready     <= w_ready_nxt;
            r_stall     <= w_stall_nxt;
            r_mem_read  <= w_mem_read_nxt;
            r_mem_write <= w_mem_write_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_tag[s][w]  <= '0;
                    r_data[s][w] <= '0;
                end
            end
        end else begin
            if (w_wr_hit) begin
                r_data[w_idx][w_hit_way]  <= i_wdata;
                r_dirty[w_idx][w_hit_way] <= 1'b1;
            end
            if (w_fill) begin
                r_tag[w_idx][r_victim]   <= w_tag;
                r_valid[w_idx][r_victim] <= 1'b1;
                r_dirty[w_idx][r_victim] <= 1'b0;
                r_data[w_idx][r_victim]  <= i_mem_rdata;
            end
        end
    end

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_acc_cnt  <= '0;
        end else begin
            if (w_hit_inc && r_hit_cnt != '1)   r_hit_cnt  <= r_hit_cnt + CNT_W'(1);
            if (w_miss_inc && r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            if (w_acc_inc && r_acc_cnt != '1)   r_acc_cnt  <= r_acc_cnt + CNT_W'(1);
        end
    end

    assign o_rdata     = r_rdata;
    assign o_ready     = r_ready;
    assign o_stall     = r_stall;
    assign o_mem_read  = r_mem_read;
    assign o_mem_write = r_mem_write;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_hit_cnt   = r_hit_cnt;
    assign o_miss_cnt  = r_miss_cnt;
    assign o_acc_cnt   = r_acc_cnt;

endmodule

// File: tb/tb_l2_cache_nway.sv
// Directed self-checking bench for l2_cache_nway (WAYS=4, IDX_W=3, CNT_W=4).
module tb_l2_cache_nway;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [29:0]  i_addr = '0;
    logic         i_read = 1'b0;
    logic         i_write = 1'b0;
    logic [127:0] i_wdata = '0;
    logic [127:0] o_rdata;
    logic         o_ready, o_stall, o_mem_read, o_mem_write;
    logic [27:0]  o_mem_addr;
    logic [127:0] o_mem_wdata;
    logic [127:0] i_mem_rdata = '0;
    logic         i_mem_ready = 1'b0;
    logic [3:0]   o_hit_cnt, o_miss_cnt, o_acc_cnt;

    l2_cache_nway #(
        .WAYS  (4),
        .IDX_W (3),
        .CNT_W (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_addr      (i_addr),
        .i_read      (i_read),
        .i_write     (i_write),
        .i_wdata     (i_wdata),
        .o_rdata     (o_rdata),
        .o_ready     (o_ready),
        .o_stall     (o_stall),
        .o_mem_read  (o_mem_read),
        .o_mem_write (o_mem_write),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_ready (i_mem_ready),
        .o_hit_cnt   (o_hit_cnt),
        .o_miss_cnt  (o_miss_cnt),
        .o_acc_cnt   (o_acc_cnt)
    );

    always #5 clk = ~clk;

    int n_asrt = 0;
    int n_fail = 0;

    logic [127:0] mem [logic [27:0]];

    int           n_cyc, n_rd, n_wr, n_rdy;
    bit           hold_bad, stall_bad, both_bad, done;
    logic [27:0]  rd_addr, wb_addr;
    logic [127:0] wb_data, got;

    function automatic logic [127:0] pat(input logic [27:0] m);
        return {4{4'hC, m}};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        i_read = 1'b0;
        i_write = 1'b0;
        i_mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One L1 request, with a memory that answers after dly held cycles.
    task automatic access(input bit rd, input logic [29:0] a,
                          input logic [127:0] wd, input int dly);
        int          wcnt, kind, pkind;
        logic [27:0] ha;
        logic [127:0] hd;
        n_cyc = 0; n_rd = 0; n_wr = 0; n_rdy = 0;
        hold_bad = 0; stall_bad = 0; both_bad = 0; done = 0;
        wcnt = 0; pkind = 0; ha = '0; hd = '0;
        @(negedge clk);
        i_addr = a; i_wdata = wd; i_read = rd; i_write = !rd;
        while (!done && n_cyc < 200) begin
            @(negedge clk);
            n_cyc++;
            i_mem_ready = 1'b0;
            if (o_mem_read && o_mem_write) both_bad = 1;
            kind = o_mem_write ? 2 : (o_mem_read ? 1 : 0);
            if (o_ready) begin
                n_rdy++;
                got = o_rdata;
                done = 1;
                i_read = 1'b0;
                i_write = 1'b0;
                if (o_stall) stall_bad = 1;
            end else if (!o_stall) begin
                stall_bad = 1;
            end
            if (kind != 0) begin
                if (kind != pkind) begin
                    wcnt = 0; ha = o_mem_addr; hd = o_mem_wdata;
                    if (kind == 2) begin
                        n_wr++; wb_addr = o_mem_addr; wb_data = o_mem_wdata;
                    end else begin
                        n_rd++; rd_addr = o_mem_addr;
                    end
                end else if (o_mem_addr !== ha || (kind == 2 && o_mem_wdata !== hd)) begin
                    hold_bad = 1;
                end
                wcnt++;
                if (wcnt > dly) begin
                    i_mem_ready = 1'b1;
                    if (kind == 2) mem[o_mem_addr] = o_mem_wdata;
                    else i_mem_rdata = mem.exists(o_mem_addr) ? mem[o_mem_addr]
                                                              : pat(o_mem_addr);
                    kind = 0;
                end
            end
            pkind = kind;
        end
        chk("req_done", 128'(done), 128'(1));
        @(negedge clk);
        if (o_ready) n_rdy++;
    endtask

    int k;

    initial begin
        mem[28'h40] = {16{8'hA5}};

        // Reset state
        do_reset();
        chk("rst_ready", 128'(o_ready), 128'(0));
        chk("rst_stall", 128'(o_stall), 128'(0));
        chk("rst_mrd", 128'(o_mem_read), 128'(0));
        chk("rst_mwr", 128'(o_mem_write), 128'(0));
        chk("rst_rdata", o_rdata, 128'(0));
        chk("rst_cnts", 128'({o_hit_cnt, o_miss_cnt, o_acc_cnt}), 128'(0));

        // Cold read then repeat hit
        access(1, 30'h0000100, '0, 0);
        chk("cold_mrd_n", 128'(n_rd), 128'(1));
        chk("cold_mwr_n", 128'(n_wr), 128'(0));
        chk("cold_maddr", 128'(rd_addr), 128'(28'h0000040));
        chk("cold_rdata", got, {16{8'hA5}});
        chk("cold_cyc", 128'(n_cyc), 128'(4));
        chk("cold_stall", 128'(stall_bad), 128'(0));
        chk("cold_miss", 128'(o_miss_cnt), 128'(1));
        chk("cold_hit", 128'(o_hit_cnt), 128'(1));
        chk("cold_acc", 128'(o_acc_cnt), 128'(1));
        access(1, 30'h0000100, '0, 0);
        chk("rep_cyc", 128'(n_cyc), 128'(2));
        chk("rep_mrd_n", 128'(n_rd), 128'(0));
        chk("rep_rdata", got, {16{8'hA5}});
        chk("rep_hit", 128'(o_hit_cnt), 128'(2));

        // LRU eviction in set 0 (tags 1..5)
        do_reset();
        for (int t = 1; t <= 4; t++) access(1, 30'(t << 5), '0, 0);
        for (int t = 1; t <= 4; t++) begin
            access(1, 30'(t << 5), '0, 0);
            chk("lru_hit_cyc", 128'(n_cyc), 128'(2));
        end
        access(1, 30'h00000A0, '0, 0);
        chk("lru_t5_mwr", 128'(n_wr), 128'(0));
        chk("lru_t5_maddr", 128'(rd_addr), 128'(28'h28));
        chk("lru_t5_rdata", got, pat(28'h28));
        access(1, 30'h0000020, '0, 0);
        chk("lru_t1_miss", 128'(n_rd), 128'(1));
        chk("lru_t1_maddr", 128'(rd_addr), 128'(28'h8));
        access(1, 30'h00000A0, '0, 0);
        chk("lru_t5_kept", 128'(n_cyc), 128'(2));
        chk("lru_cnt_hit", 128'(o_hit_cnt), 128'(11));
        chk("lru_cnt_miss", 128'(o_miss_cnt), 128'(6));
        chk("lru_cnt_acc", 128'(o_acc_cnt), 128'(11));

        // Dirty victim writeback in set 2, with slow memory
        do_reset();
        access(0, 30'h0000228, {4{32'hDEADBEEF}}, 0);
        for (int t = 18; t <= 20; t++) access(1, 30'((t << 5) | 8), '0, 0);
        access(1, 30'h00002A8, '0, 10);
        chk("wb_n", 128'(n_wr), 128'(1));
        chk("wb_addr", 128'(wb_addr), 128'(28'h8A));
        chk("wb_data", wb_data, {4{32'hDEADBEEF}});
        chk("wb_fill_n", 128'(n_rd), 128'(1));
        chk("wb_fill_addr", 128'(rd_addr), 128'(28'hAA));
        chk("wb_rdata", got, pat(28'hAA));
        chk("wb_hold", 128'(hold_bad), 128'(0));
        chk("wb_stall", 128'(stall_bad), 128'(0));
        chk("wb_excl", 128'(both_bad), 128'(0));
        chk("wb_one_ready", 128'(n_rdy), 128'(1));
        chk("wb_cyc", 128'(n_cyc), 128'(25));
        access(1, 30'h0000228, '0, 0);
        chk("wb_refetch_wr", 128'(n_wr), 128'(0));
        chk("wb_refetch", got, {4{32'hDEADBEEF}});

        // Reset in the middle of ALLOCATE
        do_reset();
        @(negedge clk);
        i_addr = 30'h0000100;
        i_read = 1'b1;
        k = 0;
        while (!o_mem_read && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("ra_reached", 128'(o_mem_read), 128'(1));
        reset = 1'b1;
        i_read = 1'b0;
        @(negedge clk);
        chk("ra_mrd", 128'(o_mem_read), 128'(0));
        chk("ra_mwr", 128'(o_mem_write), 128'(0));
        chk("ra_stall", 128'(o_stall), 128'(0));
        chk("ra_cnts", 128'({o_hit_cnt, o_miss_cnt, o_acc_cnt}), 128'(0));
        reset = 1'b0;
        access(1, 30'h0000100, '0, 0);
        chk("ra_miss_again", 128'(n_rd), 128'(1));
        chk("ra_rdata", got, {16{8'hA5}});
        chk("ra_miss_cnt", 128'(o_miss_cnt), 128'(1));

        // Counter saturation at 4 bits
        for (int i = 0; i < 20; i++) access(1, 30'h0000100, '0, 0);
        chk("sat_cyc", 128'(n_cyc), 128'(2));
        chk("sat_hit", 128'(o_hit_cnt), 128'(15));
        chk("sat_acc", 128'(o_acc_cnt), 128'(15));
        chk("sat_miss", 128'(o_miss_cnt), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
